// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit redirect, instruction-memory and decode-side signal bundle
//
// Ports (modport master = fetch_unit side, slave = environment side):
//   redirect_valid/redirect_pc           branch/jump redirect request and target
//   imem_req_valid/imem_req_addr/ready   fetch request handshake
//   imem_resp_valid/imem_resp_data       in-order instruction responses
//   out_valid/out_pc/out_inst/out_ready  fetch-queue head towards decode
//   halt/err                             sticky halt status
//   pc/system_counter/last_pc/last_inst  observation outputs
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_inst;
    logic            out_ready;
    logic            halt;
    logic            err;
    logic [XLEN-1:0] pc;
    logic [31:0]     system_counter;
    logic [XLEN-1:0] last_pc;
    logic [XLEN-1:0] last_inst;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid,
               imem_resp_data, out_ready,
        output imem_req_valid, imem_req_addr, out_valid, out_pc, out_inst,
               halt, err, pc, system_counter, last_pc, last_inst
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid,
               imem_resp_data, out_ready,
        input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_inst,
               halt, err, pc, system_counter, last_pc, last_inst
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit with fetch queue, redirect squash and halt detection
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  fetch_unit_if.master: redirect in, imem request/response, queue head out,
//        halt/err status, pc, system_counter, last_pc/last_inst
module fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] START_ADDR = 'h1000,
    parameter logic [XLEN-1:0] OK_OFS     = 'h8080,
    parameter logic [XLEN-1:0] ERR_OFS    = 'h4040,
    parameter int              DEPTH      = 4
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam int              AW       = $clog2(DEPTH);
    localparam int              CW       = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
    localparam logic [XLEN-1:0] OK_ADDR  = START_ADDR + OK_OFS;
    localparam logic [XLEN-1:0] ERR_ADDR = START_ADDR + ERR_OFS;

    typedef enum logic [1:0] {RUN, HALT_OK, HALT_ERR} state_t;

    state_t          state;
    logic [XLEN-1:0] pc_q;
    // PC belonging to the next response that will be kept. Kept responses are
    // always a contiguous +4 run starting at the latest redirect target (every
    // older request is squashed), so one register tracks request PCs in order.
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outst;
    logic [CW-1:0]   drop;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0] inst_mem [DEPTH];
    logic            halt_q;
    logic            err_q;
    logic [31:0]     cycle_q;
    logic [XLEN-1:0] last_pc_q;
    logic [XLEN-1:0] last_inst_q;

    logic            running;
    logic            redirect;
    logic            at_halt_addr;
    logic [CW:0]     occupancy;
    logic            req_valid;
    logic            accept;
    logic            drop_resp;
    logic            push;
    logic            pop;

    always_comb begin
        running      = (state == RUN);
        redirect     = running && bus.redirect_valid;
        at_halt_addr = (pc_q == OK_ADDR) || (pc_q == ERR_ADDR);
        // Queue slots are reserved at request time, so a response always has room.
        occupancy    = {1'b0, count} + {1'b0, outst};
        req_valid    = !rst && running && !bus.redirect_valid && !at_halt_addr
                       && (occupancy < {1'b0, DEPTH_C});
        accept       = req_valid && bus.imem_req_ready;
        // A response landing in the redirect cycle belongs to the old path.
        drop_resp    = bus.imem_resp_valid && (redirect || (drop != '0));
        push         = bus.imem_resp_valid && !drop_resp;
        pop          = (count != '0) && bus.out_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            pc_q        <= START_ADDR;
            resp_pc     <= START_ADDR;
            count       <= '0;
            outst       <= '0;
            drop        <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            halt_q      <= 1'b0;
            err_q       <= 1'b0;
            cycle_q     <= '0;
            last_pc_q   <= '0;
            last_inst_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;

            case (state)
                RUN: begin
                    if (bus.redirect_valid) begin
                        pc_q <= bus.redirect_pc;
                    end else if (pc_q == OK_ADDR) begin
                        state  <= HALT_OK;
                        halt_q <= 1'b1;
                    end else if (pc_q == ERR_ADDR) begin
                        state  <= HALT_ERR;
                        halt_q <= 1'b1;
                        err_q  <= 1'b1;
                    end else if (accept) begin
                        pc_q <= pc_q + XLEN'(4);
                    end
                end
                default: ;
            endcase

            outst <= outst + CW'(accept) - CW'(bus.imem_resp_valid);

            // Everything still in flight after a redirect is stale; that count
            // already includes requests marked by earlier redirects.
            if (redirect) begin
                drop <= outst - CW'(bus.imem_resp_valid);
            end else if (bus.imem_resp_valid && (drop != '0)) begin
                drop <= drop - CW'(1);
            end

            if (redirect) begin
                resp_pc <= bus.redirect_pc;
            end else if (push) begin
                resp_pc <= resp_pc + XLEN'(4);
            end

            if (redirect) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end

            if (pop) begin
                last_pc_q   <= pc_mem[rd_ptr];
                last_inst_q <= inst_mem[rd_ptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            pc_mem[wr_ptr]   <= resp_pc;
            inst_mem[wr_ptr] <= bus.imem_resp_data;
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.out_valid      = (count != '0);
    assign bus.out_pc         = pc_mem[rd_ptr];
    assign bus.out_inst       = inst_mem[rd_ptr];
    assign bus.halt           = halt_q;
    assign bus.err            = err_q;
    assign bus.pc             = pc_q;
    assign bus.system_counter = cycle_q;
    assign bus.last_pc        = last_pc_q;
    assign bus.last_inst      = last_inst_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit
`timescale 1ns/1ps
module tb_fetch_unit;
    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] START    = 32'h1000;
    localparam logic [31:0] OK_ADDR  = 32'h9080;
    localparam logic [31:0] ERR_ADDR = 32'h5040;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if #(.XLEN(XLEN)) bus ();

    fetch_unit #(
        .XLEN(XLEN), .START_ADDR(START), .OK_OFS(32'h8080),
        .ERR_OFS(32'h4040), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int mem_lat = 1;
    int mem_ready_pct = 100;
    int cyc = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;
    req_t pend[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // Instruction memory: in-order responses, at least mem_lat cycles after acceptance.
    initial begin
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) pend.delete();
            else if (bus.imem_req_valid && bus.imem_req_ready)
                pend.push_back('{addr: bus.imem_req_addr, due: cyc + mem_lat});
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                pend.delete();
                bus.imem_resp_valid = 1'b0;
            end else if (pend.size() > 0 && pend[0].due <= cyc) begin
                bus.imem_resp_valid = 1'b1;
                bus.imem_resp_data  = mem_word(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                bus.imem_resp_valid = 1'b0;
            end
            bus.imem_req_ready = ($urandom_range(99) < mem_ready_pct);
        end
    end

    // Per-cycle observations taken at the falling edge.
    logic        s_pop, s_fire, s_outv, s_reqv, s_resp, s_halt, s_err;
    logic [31:0] s_pc, s_inst, s_addr, s_pcreg;

    task automatic tick(input logic ordy, input logic rv, input logic [31:0] rpc);
        bus.out_ready      = ordy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        @(negedge clk);
        s_outv  = bus.out_valid;
        s_pop   = bus.out_valid && ordy;
        s_pc    = bus.out_pc;
        s_inst  = bus.out_inst;
        s_reqv  = bus.imem_req_valid;
        s_fire  = bus.imem_req_valid && bus.imem_req_ready;
        s_addr  = bus.imem_req_addr;
        s_resp  = bus.imem_resp_valid;
        s_halt  = bus.halt;
        s_err   = bus.err;
        s_pcreg = bus.pc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b0;
        @(posedge clk);
        #2;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        n_vec++; if (bus.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_req_valid got=%b exp=0", bus.imem_req_valid); end
        n_vec++; if (bus.halt !== 1'b0 || bus.err !== 1'b0) begin n_err++; $display("FAIL reset_halt_err got=%b%b exp=00", bus.halt, bus.err); end
        n_vec++; if (bus.pc !== START) begin n_err++; $display("FAIL reset_pc got=%h exp=%h", bus.pc, START); end
        n_vec++; if (bus.system_counter !== 32'd0) begin n_err++; $display("FAIL reset_counter got=%0d exp=0", bus.system_counter); end
        n_vec++; if (bus.last_pc !== 32'd0 || bus.last_inst !== 32'd0) begin n_err++; $display("FAIL reset_last got=%h/%h exp=0/0", bus.last_pc, bus.last_inst); end
    endtask

    task automatic test_sequential();
        logic [31:0] ereq, epop;
        int pops;
        mem_lat = 1; mem_ready_pct = 100;
        do_reset();
        ereq = START; epop = START; pops = 0;
        for (int i = 0; i < 24; i++) begin
            tick(1'b1, 1'b0, 32'd0);
            if (s_fire) begin
                n_vec++; if (s_addr !== ereq) begin n_err++; $display("FAIL seq_req_addr got=%h exp=%h", s_addr, ereq); end
                ereq += 4;
            end
            if (s_pop) begin
                n_vec++; if (s_pc !== epop || s_inst !== mem_word(epop)) begin n_err++; $display("FAIL seq_pop got=%h/%h exp=%h/%h", s_pc, s_inst, epop, mem_word(epop)); end
                epop += 4; pops++;
            end
        end
        n_vec++; if (pops != 22) begin n_err++; $display("FAIL seq_pop_count got=%0d exp=22", pops); end
    endtask

    task automatic test_backpressure();
        logic [31:0] epop;
        int fires, pops;
        mem_lat = 1; mem_ready_pct = 100;
        do_reset();
        fires = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 1'b0, 32'd0);
            if (s_fire) begin
                n_vec++; if (s_addr !== START + 32'(4 * fires)) begin n_err++; $display("FAIL bp_req_addr got=%h exp=%h", s_addr, START + 32'(4 * fires)); end
                fires++;
            end
        end
        n_vec++; if (fires != DEPTH) begin n_err++; $display("FAIL bp_fire_count got=%0d exp=%0d", fires, DEPTH); end
        n_vec++; if (s_outv !== 1'b1 || s_reqv !== 1'b0) begin n_err++; $display("FAIL bp_full_state got=v%b/req%b exp=v1/req0", s_outv, s_reqv); end
        epop = START; pops = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 1'b0, 32'd0);
            if (s_pop) begin
                n_vec++; if (s_pc !== epop || s_inst !== mem_word(epop)) begin n_err++; $display("FAIL bp_pop got=%h/%h exp=%h/%h", s_pc, s_inst, epop, mem_word(epop)); end
                epop += 4; pops++;
            end
        end
        n_vec++; if (pops < DEPTH) begin n_err++; $display("FAIL bp_drain_count got=%0d exp>=%0d", pops, DEPTH); end
    endtask

    task automatic test_redirect_drop();
        int out_n;
        logic done, seen;
        mem_lat = 3; mem_ready_pct = 100;
        do_reset();
        out_n = 0; done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (out_n == 2) begin
                tick(1'b0, 1'b1, 32'h2000);
                done = 1'b1;
                n_vec++; if (s_fire !== 1'b0) begin n_err++; $display("FAIL rd_no_req_on_redirect got=%b exp=0", s_fire); end
            end else begin
                tick(1'b0, 1'b0, 32'd0);
            end
            out_n += int'(s_fire) - int'(s_resp);
        end
        n_vec++; if (!done) begin n_err++; $display("FAIL rd_two_outstanding got=%0d exp=2", out_n); end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(1'b1, 1'b0, 32'd0);
            if (s_pop) begin
                seen = 1'b1;
                n_vec++; if (s_pc !== 32'h2000 || s_inst !== mem_word(32'h2000)) begin n_err++; $display("FAIL rd_first_pop got=%h/%h exp=%h/%h", s_pc, s_inst, 32'h2000, mem_word(32'h2000)); end
            end
        end
        n_vec++; if (!seen) begin n_err++; $display("FAIL rd_pop_timeout got=0 exp=1"); end
        tick(1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 10 && !s_pop; i++) tick(1'b1, 1'b0, 32'd0);
        n_vec++; if (s_pc !== 32'h2004) begin n_err++; $display("FAIL rd_second_pop got=%h exp=%h", s_pc, 32'h2004); end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, ereq, rpc;
        logic ordy, rv, prev_rv;
        int out_n;
        for (int r = 0; r < 3; r++) begin
            mem_lat = r + 1; mem_ready_pct = 70;
            do_reset();
            exp_pc = START; ereq = START; out_n = 0; prev_rv = 1'b0;
            for (int i = 0; i < 300; i++) begin
                ordy = ($urandom_range(3) != 0);
                rv   = ($urandom_range(9) == 0);
                rpc  = 32'h3000 + 32'($urandom_range(1023) * 4);
                tick(ordy, rv, rpc);
                if (prev_rv) begin
                    n_vec++; if (s_outv !== 1'b0) begin n_err++; $display("FAIL rnd_flush got=%b exp=0", s_outv); end
                end
                if (rv) begin
                    n_vec++; if (s_fire !== 1'b0) begin n_err++; $display("FAIL rnd_req_on_redirect got=%b exp=0", s_fire); end
                end
                if (s_fire) begin
                    n_vec++; if (s_addr !== ereq) begin n_err++; $display("FAIL rnd_req_addr got=%h exp=%h", s_addr, ereq); end
                    ereq += 4;
                end
                if (s_pop) begin
                    n_vec++; if (s_pc !== exp_pc || s_inst !== mem_word(exp_pc)) begin n_err++; $display("FAIL rnd_pop got=%h/%h exp=%h/%h", s_pc, s_inst, exp_pc, mem_word(exp_pc)); end
                    exp_pc += 4;
                end
                if (rv) begin exp_pc = rpc; ereq = rpc; end
                out_n += int'(s_fire) - int'(s_resp);
                if (out_n > DEPTH) begin n_vec++; n_err++; $display("FAIL rnd_outstanding got=%0d exp<=%0d", out_n, DEPTH); end
                prev_rv = rv;
            end
        end
    endtask

    task automatic test_halt_ok();
        int fires, pops;
        logic [31:0] epop;
        mem_lat = 1; mem_ready_pct = 100;
        do_reset();
        repeat (3) tick(1'b0, 1'b0, 32'd0);
        tick(1'b0, 1'b1, OK_ADDR);
        tick(1'b0, 1'b0, 32'd0);
        n_vec++; if (s_pcreg !== OK_ADDR || s_fire !== 1'b0 || s_halt !== 1'b0) begin n_err++; $display("FAIL hok_at_addr got=pc%h/req%b/h%b exp=pc%h/req0/h0", s_pcreg, s_fire, s_halt, OK_ADDR); end
        tick(1'b0, 1'b0, 32'd0);
        n_vec++; if (s_halt !== 1'b1 || s_err !== 1'b0) begin n_err++; $display("FAIL hok_halt got=%b%b exp=10", s_halt, s_err); end
        tick(1'b0, 1'b1, 32'h2000);
        tick(1'b0, 1'b0, 32'd0);
        n_vec++; if (s_pcreg !== OK_ADDR || s_halt !== 1'b1 || s_reqv !== 1'b0) begin n_err++; $display("FAIL hok_redirect_ignored got=pc%h/h%b/req%b exp=pc%h/h1/req0", s_pcreg, s_halt, s_reqv, OK_ADDR); end
        // Requests in flight when the halt address is reached still drain.
        mem_lat = 3;
        do_reset();
        tick(1'b0, 1'b1, 32'h9078);
        fires = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0, 32'd0);
            if (s_fire) begin
                n_vec++; if (s_addr !== 32'h9078 + 32'(4 * fires)) begin n_err++; $display("FAIL hok_drain_req got=%h exp=%h", s_addr, 32'h9078 + 32'(4 * fires)); end
                fires++;
            end
        end
        n_vec++; if (fires != 2 || s_halt !== 1'b1) begin n_err++; $display("FAIL hok_drain_fires got=%0d/h%b exp=2/h1", fires, s_halt); end
        epop = 32'h9078; pops = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b0, 32'd0);
            if (s_pop) begin
                n_vec++; if (s_pc !== epop || s_inst !== mem_word(epop)) begin n_err++; $display("FAIL hok_drain_pop got=%h/%h exp=%h/%h", s_pc, s_inst, epop, mem_word(epop)); end
                epop += 4; pops++;
            end
        end
        n_vec++; if (pops != 2) begin n_err++; $display("FAIL hok_drain_count got=%0d exp=2", pops); end
    endtask

    task automatic test_halt_err_reset();
        logic fseen, pseen;
        mem_lat = 1; mem_ready_pct = 100;
        do_reset();
        repeat (6) tick(1'b1, 1'b0, 32'd0);
        tick(1'b1, 1'b1, ERR_ADDR);
        tick(1'b1, 1'b0, 32'd0);
        tick(1'b1, 1'b0, 32'd0);
        n_vec++; if (s_halt !== 1'b1 || s_err !== 1'b1) begin n_err++; $display("FAIL herr_halt got=%b%b exp=11", s_halt, s_err); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if (bus.halt !== 1'b0 || bus.err !== 1'b0 || bus.out_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL herr_async_ctl got=h%b e%b v%b r%b exp=0000", bus.halt, bus.err, bus.out_valid, bus.imem_req_valid); end
        n_vec++; if (bus.pc !== START || bus.system_counter !== 32'd0) begin n_err++; $display("FAIL herr_async_pc got=%h/%0d exp=%h/0", bus.pc, bus.system_counter, START); end
        n_vec++; if (bus.last_pc !== 32'd0 || bus.last_inst !== 32'd0) begin n_err++; $display("FAIL herr_async_last got=%h/%h exp=0/0", bus.last_pc, bus.last_inst); end
        do_reset();
        fseen = 1'b0; pseen = 1'b0;
        for (int i = 0; i < 10 && !(fseen && pseen); i++) begin
            tick(1'b1, 1'b0, 32'd0);
            if (s_fire && !fseen) begin
                fseen = 1'b1;
                n_vec++; if (s_addr !== START) begin n_err++; $display("FAIL herr_resume_req got=%h exp=%h", s_addr, START); end
            end
            if (s_pop && !pseen) begin
                pseen = 1'b1;
                n_vec++; if (s_pc !== START) begin n_err++; $display("FAIL herr_resume_pop got=%h exp=%h", s_pc, START); end
            end
        end
        n_vec++; if (!(fseen && pseen)) begin n_err++; $display("FAIL herr_resume_timeout got=%b%b exp=11", fseen, pseen); end
    endtask

    task automatic test_push_pop();
        logic [31:0] epop;
        int pops, ticks;
        mem_lat = 1; mem_ready_pct = 100;
        do_reset();
        ticks = 0;
        for (int i = 0; i < 8; i++) begin tick(1'b0, 1'b0, 32'd0); ticks++; end
        n_vec++; if (s_outv !== 1'b1 || s_reqv !== 1'b0) begin n_err++; $display("FAIL pp_full got=v%b/req%b exp=v1/req0", s_outv, s_reqv); end
        epop = START; pops = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, 1'b0, 32'd0); ticks++;
            if (s_pop) begin
                n_vec++; if (s_pc !== epop || s_inst !== mem_word(epop)) begin n_err++; $display("FAIL pp_order got=%h/%h exp=%h/%h", s_pc, s_inst, epop, mem_word(epop)); end
                epop += 4; pops++;
            end
        end
        n_vec++; if (pops != 16) begin n_err++; $display("FAIL pp_every_cycle got=%0d exp=16", pops); end
        n_vec++; if (bus.last_pc !== epop - 32'd4) begin n_err++; $display("FAIL pp_last_pc got=%h exp=%h", bus.last_pc, epop - 32'd4); end
        n_vec++; if (bus.system_counter !== 32'(ticks)) begin n_err++; $display("FAIL pp_counter got=%0d exp=%0d", bus.system_counter, ticks); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_drop();
        test_random();
        test_halt_ok();
        test_halt_err_reset();
        test_push_pop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
